// File: rtl/sa_cache_mem_responder.sv
// Secondary-memory responder: accepts one cache read/write request at a time and
// completes it against an internal word array after a fixed LATENCY.
module sa_cache_mem_responder #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int STORE_AW = 12,
  parameter int LATENCY  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_rw,
  input  logic              mem_req_valid,
  output logic [DATA_W-1:0] mem_rsp_data,
  output logic              mem_rsp_ready,
  output logic              mem_busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t              state, state_nx;
  logic [7:0]          cnt;
  logic [STORE_AW-1:0] idx_q;
  logic [DATA_W-1:0]   data_q;
  logic                rw_q;

  logic                acc;
  logic                acc_rw;
  logic [STORE_AW-1:0] acc_idx;
  logic [DATA_W-1:0]   acc_data;

  logic [DATA_W-1:0]   store [2**STORE_AW];

  // Address bits above the store index alias onto the same word.
  logic addr_hi_unused;
  assign addr_hi_unused = ^mem_req_addr[ADDR_W-1:STORE_AW];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (mem_req_valid) state_nx = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == 8'd1) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_rsp_ready = (state == RESP);
    mem_busy      = (state != IDLE);
  end

  // With LATENCY=1 the access happens on the acceptance edge straight from the inputs.
  always_comb begin
    acc      = 1'b0;
    acc_rw   = rw_q;
    acc_idx  = idx_q;
    acc_data = data_q;
    if (state == IDLE && mem_req_valid && LATENCY == 1) begin
      acc      = 1'b1;
      acc_rw   = mem_req_rw;
      acc_idx  = mem_req_addr[STORE_AW-1:0];
      acc_data = mem_req_data;
    end else if (state == BUSY && cnt == 8'd1) begin
      acc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      mem_rsp_data <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      if (state == IDLE && mem_req_valid) begin
        idx_q  <= mem_req_addr[STORE_AW-1:0];
        data_q <= mem_req_data;
        rw_q   <= mem_req_rw;
        cnt    <= CNT_INIT;
      end else if (state == BUSY && cnt != 8'd1) begin
        cnt <= cnt - 8'd1;
      end
      if (acc) begin
        if (acc_rw) begin
          if (wr_count != '1) wr_count <= wr_count + 16'd1;
        end else begin
          mem_rsp_data <= store[acc_idx];
          if (rd_count != '1) rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc && acc_rw && !rst) store[acc_idx] <= acc_data;
  end

endmodule

// File: tb/tb_sa_cache_mem_responder.sv
// Bench for sa_cache_mem_responder: two instances (LATENCY 4 and 1) driven by
// directed and random transactions and checked against a transaction-level model.
module tb_sa_cache_mem_responder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic        req_rw    [2];
  logic        req_valid [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_ready [2];
  logic        busy      [2];
  logic [15:0] rd_cnt    [2];
  logic [15:0] wr_cnt    [2];

  always #5 clk = ~clk;

  sa_cache_mem_responder #(.ADDR_W(20), .DATA_W(32), .STORE_AW(12), .LATENCY(LAT0)) u_lat4 (
    .clk(clk), .rst(rst),
    .mem_req_addr(req_addr[0]), .mem_req_data(req_data[0]),
    .mem_req_rw(req_rw[0]), .mem_req_valid(req_valid[0]),
    .mem_rsp_data(rsp_data[0]), .mem_rsp_ready(rsp_ready[0]), .mem_busy(busy[0]),
    .rd_count(rd_cnt[0]), .wr_count(wr_cnt[0])
  );

  sa_cache_mem_responder #(.ADDR_W(20), .DATA_W(32), .STORE_AW(12), .LATENCY(LAT1)) u_lat1 (
    .clk(clk), .rst(rst),
    .mem_req_addr(req_addr[1]), .mem_req_data(req_data[1]),
    .mem_req_rw(req_rw[1]), .mem_req_valid(req_valid[1]),
    .mem_rsp_data(rsp_data[1]), .mem_rsp_ready(rsp_ready[1]), .mem_busy(busy[1]),
    .rd_count(rd_cnt[1]), .wr_count(wr_cnt[1])
  );

  // Reference model: word store per instance, completion counts, last read value.
  logic [31:0] mdl_mem  [2][4096];
  int unsigned mdl_rd   [2];
  int unsigned mdl_wr   [2];
  logic [31:0] mdl_last [2];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lat_of(input int sel);
    return (sel != 0) ? LAT1 : LAT0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mdl_rd[s]   = 0;
      mdl_wr[s]   = 0;
      mdl_last[s] = '0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int s = 0; s < 2; s++) req_valid[s] = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge with the target instance idle; leaves it idle at a negedge.
  task automatic do_req(input int sel, input logic rw, input logic [19:0] addr,
                        input logic [31:0] data, input bit hold, input bit glitch);
    int  lat;
    int  cyc;
    bit  got;
    int  idx;
    lat = lat_of(sel);
    idx = int'(addr % 20'd4096);
    req_valid[1-sel] = 1'b0;
    req_addr[sel]    = addr;
    req_data[sel]    = data;
    req_rw[sel]      = rw;
    req_valid[sel]   = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < lat + 4) begin
      @(negedge clk);
      cyc++;
      if (rsp_ready[sel]) got = 1'b1;
      else begin
        check("busy_wait", 32'(busy[sel]), 32'd1);
        if (glitch) begin
          req_addr[sel]  = 20'($urandom);
          req_data[sel]  = $urandom;
          req_valid[sel] = 1'b0;
        end
      end
    end
    if (rw) begin
      mdl_mem[sel][idx] = data;
      if (mdl_wr[sel] < 65535) mdl_wr[sel]++;
    end else begin
      mdl_last[sel] = mdl_mem[sel][idx];
      if (mdl_rd[sel] < 65535) mdl_rd[sel]++;
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    else begin
      check("latency", 32'(cyc), 32'(lat));
      check(rw ? "rsp_hold" : "rd_data", rsp_data[sel], mdl_last[sel]);
      check("resp_busy", 32'(busy[sel]), 32'd1);
      check("rd_count", 32'(rd_cnt[sel]), mdl_rd[sel]);
      check("wr_count", 32'(wr_cnt[sel]), mdl_wr[sel]);
    end
    if (!hold) req_valid[sel] = 1'b0;
    @(negedge clk);
    check("ready_pulse", 32'(rsp_ready[sel]), 32'd0);
    check("idle_busy", 32'(busy[sel]), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_addr[s]  = '0;
      req_data[s]  = '0;
      req_rw[s]    = 1'b0;
      req_valid[s] = 1'b0;
      for (int i = 0; i < 4096; i++) mdl_mem[s][i] = '0;
    end
    model_reset();

    do_reset(2);
    repeat (10) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check("rst_ready", 32'(rsp_ready[s]), 32'd0);
        check("rst_busy", 32'(busy[s]), 32'd0);
        check("rst_data", rsp_data[s], 32'd0);
        check("rst_rd", 32'(rd_cnt[s]), 32'd0);
        check("rst_wr", 32'(wr_cnt[s]), 32'd0);
      end
    end

    do_req(0, 1'b1, 20'h00123, 32'hDEADBEEF, 1'b1, 1'b0);
    do_req(0, 1'b0, 20'h00123, 32'h0, 1'b0, 1'b0);

    do_req(0, 1'b1, 20'h00010, 32'hCAFEF00D, 1'b1, 1'b0);
    do_req(0, 1'b0, 20'h00010, 32'h0, 1'b0, 1'b0);

    do_req(1, 1'b1, 20'h01005, 32'h0000A5A5, 1'b0, 1'b0);
    do_req(1, 1'b0, 20'h00005, 32'h0, 1'b0, 1'b0);

    // Abort an in-flight write two cycles after acceptance.
    req_addr[0]  = 20'h00040;
    req_data[0]  = 32'h11111111;
    req_rw[0]    = 1'b1;
    req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    do_reset(1);
    repeat (LAT0 + 2) begin
      @(negedge clk);
      check("abort_ready", 32'(rsp_ready[0]), 32'd0);
      check("abort_busy", 32'(busy[0]), 32'd0);
    end
    do_req(0, 1'b0, 20'h00040, 32'h0, 1'b0, 1'b0);

    do_req(0, 1'b1, 20'h00077, 32'h5A5A1234, 1'b0, 1'b1);
    do_req(0, 1'b0, 20'h00077, 32'h0, 1'b0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      int          sel;
      logic [19:0] addr;
      sel = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) addr = {8'($urandom), 12'($urandom_range(0, 15))};
      else addr = 20'($urandom);
      do_req(sel, 1'($urandom_range(0, 1)), addr, $urandom,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    for (int s = 0; s < 2; s++) req_valid[s] = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
